// File: rtl/input_event_capture.sv
// Turns qualifying edges of a debounced level into event pulses, a saturating
// count and a sticky interrupt flag, with a programmable re-trigger hold-off.
module input_event_capture #(
  parameter int COUNT_WIDTH   = 16,
  parameter int HOLDOFF_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resn,
  input  logic                     sync_in,
  input  logic                     enable,
  input  logic [1:0]               edge_sel,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff,
  input  logic                     count_clear,
  input  logic                     irq_ack,
  output logic                     level,
  output logic                     event_pulse,
  output logic                     last_edge,
  output logic [COUNT_WIDTH-1:0]   event_count,
  output logic                     irq_pending,
  output logic                     overrun
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t                   r_state;
  logic [HOLDOFF_WIDTH-1:0] r_holdCnt;
  logic                     r_level;
  logic                     r_eventPulse;
  logic                     r_lastEdge;
  logic [COUNT_WIDTH-1:0]   r_eventCount;
  logic                     r_irqPending;
  logic                     r_overrun;

  logic w_rise;
  logic w_fall;
  logic w_accept;
  logic w_countFull;

  assign w_rise      = sync_in & ~r_level;
  assign w_fall      = ~sync_in & r_level;
  assign w_accept    = ((w_rise & edge_sel[0]) | (w_fall & edge_sel[1])) & (r_state == S_ARMED);
  assign w_countFull = (r_eventCount == {COUNT_WIDTH{1'b1}});

  // IDLE always lasts at least one edge after reset so r_level holds a real
  // sample of sync_in before any edge can be detected.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_state      <= S_IDLE;
      r_holdCnt    <= '0;
      r_level      <= 1'b0;
      r_eventPulse <= 1'b0;
      r_lastEdge   <= 1'b0;
      r_eventCount <= '0;
      r_irqPending <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_level      <= sync_in;
      r_eventPulse <= w_accept;

      if (w_accept) begin
        r_lastEdge <= w_rise;
      end

      if (count_clear) begin
        r_eventCount <= w_accept ? {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : '0;
      end else if (w_accept && !w_countFull) begin
        r_eventCount <= r_eventCount + 1'b1;
      end

      // An acknowledge coinciding with a new event keeps the flag set but
      // clears overrun, since software has just serviced the previous event.
      if (w_accept) begin
        r_irqPending <= 1'b1;
      end else if (irq_ack) begin
        r_irqPending <= 1'b0;
      end

      if (irq_ack) begin
        r_overrun <= 1'b0;
      end else if (w_accept && r_irqPending) begin
        r_overrun <= 1'b1;
      end

      if (!enable) begin
        r_state   <= S_IDLE;
        r_holdCnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_ARMED;
          end
          S_ARMED: begin
            if (w_accept && (holdoff != '0)) begin
              r_state   <= S_HOLDOFF;
              r_holdCnt <= holdoff;
            end
          end
          S_HOLDOFF: begin
            if (r_holdCnt == {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1}) begin
              r_state <= S_ARMED;
            end
            r_holdCnt <= r_holdCnt - 1'b1;
          end
          default: begin
            r_state   <= S_IDLE;
            r_holdCnt <= '0;
          end
        endcase
      end
    end
  end

  assign level       = r_level;
  assign event_pulse = r_eventPulse;
  assign last_edge   = r_lastEdge;
  assign event_count = r_eventCount;
  assign irq_pending = r_irqPending;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_input_event_capture.sv
// Directed and randomized bench for input_event_capture, checked against an
// edge-by-edge behavioural model expressed as an "eligible from cycle" rule.
module tb_input_event_capture;

  localparam int CW = 4;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          resn = 1'b0;
  logic          sync_in = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    edge_sel = 2'b00;
  logic [HW-1:0] holdoff = '0;
  logic          count_clear = 1'b0;
  logic          irq_ack = 1'b0;
  logic          level;
  logic          event_pulse;
  logic          last_edge;
  logic [CW-1:0] event_count;
  logic          irq_pending;
  logic          overrun;

  input_event_capture #(.COUNT_WIDTH(CW), .HOLDOFF_WIDTH(HW)) dut (
    .clk(clk), .resn(resn), .sync_in(sync_in), .enable(enable),
    .edge_sel(edge_sel), .holdoff(holdoff), .count_clear(count_clear),
    .irq_ack(irq_ack), .level(level), .event_pulse(event_pulse),
    .last_edge(last_edge), .event_count(event_count),
    .irq_pending(irq_pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: an event is taken when the block is enabled-and-settled and the
  // current edge index has reached the end of the last hold-off window.
  int cycle = 0;
  bit mIdle;
  int eligibleAt;
  bit mLevel, mPulse, mLast, mIrq, mOvr;
  int mCount;

  task automatic modelReset();
    mIdle = 1'b1; eligibleAt = 0; mLevel = 1'b0; mPulse = 1'b0;
    mLast = 1'b0; mIrq = 1'b0; mOvr = 1'b0; mCount = 0;
  endtask

  task automatic modelEdge();
    bit r, f, acc;
    r   = sync_in && !mLevel;
    f   = !sync_in && mLevel;
    acc = ((r && edge_sel[0]) || (f && edge_sel[1])) && !mIdle && (cycle >= eligibleAt);
    mPulse = acc;
    if (acc) mLast = r;
    if (count_clear) mCount = acc ? 1 : 0;
    else if (acc) mCount = (mCount + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : mCount + 1;
    if (irq_ack) mOvr = 1'b0;
    else if (acc && mIrq) mOvr = 1'b1;
    if (acc) mIrq = 1'b1;
    else if (irq_ack) mIrq = 1'b0;
    if (!enable) mIdle = 1'b1;
    else if (mIdle) begin
      mIdle = 1'b0;
      eligibleAt = cycle + 1;
    end else if (acc && holdoff != '0) begin
      eligibleAt = cycle + int'(holdoff) + 1;
    end
    mLevel = sync_in;
    cycle++;
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkOne("level", 32'(level), 32'(mLevel));
    checkOne("event_pulse", 32'(event_pulse), 32'(mPulse));
    checkOne("last_edge", 32'(last_edge), 32'(mLast));
    checkOne("event_count", 32'(event_count), 32'(mCount));
    checkOne("irq_pending", 32'(irq_pending), 32'(mIrq));
    checkOne("overrun", 32'(overrun), 32'(mOvr));
  endtask

  task automatic applyStimulus(input logic s, input logic en, input logic [1:0] es,
                               input logic [HW-1:0] ho, input logic cc, input logic ack);
    sync_in = s; enable = en; edge_sel = es; holdoff = ho;
    count_clear = cc; irq_ack = ack;
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    modelReset();
    #1;
    checkOutput();
    #11 resn = 1'b1;

    // sync_in high through reset release must not look like a rising edge
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 2'b01, 8'd0, 1'b0, 1'b0);
    checkOne("noSpuriousCount", 32'(event_count), 32'd0);

    // Back-to-back toggles with no hold-off
    for (int i = 0; i < 6; i++) applyStimulus(i[0] ? 1'b1 : 1'b0, 1'b1, 2'b11, 8'd0, 1'b0, 1'b0);
    checkOne("toggleCount", 32'(event_count), 32'd6);
    checkOne("toggleLastEdge", 32'(last_edge), 32'd1);
    checkOne("toggleOverrun", 32'(overrun), 32'd1);

    // Hold-off window of 4: edges at 2 and 4 lost, edge at 6 taken
    applyStimulus(1'b0, 1'b1, 2'b00, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b00, 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b11, 8'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 8'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b11, 8'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b11, 8'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 8'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 8'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b11, 8'd4, 1'b0, 1'b0);
    checkOne("holdoffAccept", 32'(event_pulse), 32'd1);
    checkOne("holdoffCount", 32'(event_count), 32'd2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 2'b11, 8'd0, 1'b0, 1'b0);

    // Saturation, then clear coincident with an event
    for (int i = 0; i < 18; i++) applyStimulus(i[0] ? 1'b0 : 1'b1, 1'b1, 2'b11, 8'd0, 1'b0, 1'b0);
    checkOne("saturated", 32'(event_count), 32'hF);
    applyStimulus(1'b1, 1'b1, 2'b11, 8'd0, 1'b1, 1'b0);
    checkOne("clearWithEvent", 32'(event_count), 32'd1);

    // Acknowledge coincident with an event, then alone
    applyStimulus(1'b0, 1'b1, 2'b11, 8'd0, 1'b0, 1'b1);
    checkOne("ackEventIrq", 32'(irq_pending), 32'd1);
    checkOne("ackEventOverrun", 32'(overrun), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b11, 8'd0, 1'b0, 1'b1);
    checkOne("ackAloneIrq", 32'(irq_pending), 32'd0);
    checkOne("ackAloneOverrun", 32'(overrun), 32'd0);

    // Disable during hold-off, re-enable, edge two cycles later is taken
    applyStimulus(1'b1, 1'b1, 2'b11, 8'd6, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 8'd6, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b11, 8'd6, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b11, 8'd6, 1'b0, 1'b0);
    checkOne("disableKeepsIrq", 32'(irq_pending), 32'd1);
    applyStimulus(1'b1, 1'b1, 2'b11, 8'd6, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 8'd6, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b11, 8'd6, 1'b0, 1'b0);
    checkOne("reenableAccept", 32'(event_pulse), 32'd1);

    // Asynchronous reset during a hold-off window
    applyStimulus(1'b1, 1'b1, 2'b11, 8'd8, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 8'd8, 1'b0, 1'b0);
    #2 resn = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    resn = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) != 0),
                    2'($urandom_range(0, 3)), HW'($urandom_range(0, 5)),
                    1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_event_capture.md
# input_event_capture

Event capture stage directly downstream of the input debounce synchronizer: it consumes the synchronized, debounced level and turns qualifying transitions into one-cycle event pulses, a saturating event count and a sticky interrupt flag with acknowledge. Its output feeds the register file and interrupt aggregation logic. A programmable hold-off window rejects re-triggering after each accepted event.

## Interface
- COUNT_WIDTH, 16: width of event counter
- HOLDOFF_WIDTH, 8: width of hold-off length input/counter

- clk  in  1  system clock, all logic on rising edge
- resn  in  1  reset, asynchronous, active-low
- sync_in  in  1  debounced level from the synchronizer (already in clk domain)
- enable  in  1  capture enable
- edge_sel  in  2  00 none, 01 rising, 10 falling, 11 both
- holdoff  in  HOLDOFF_WIDTH  cycles of re-trigger rejection after an accepted event (0 = none)
- count_clear  in  1  one-cycle pulse, clears event_count
- irq_ack  in  1  one-cycle pulse, clears irq_pending and overrun
- level  out  1  registered copy of sync_in
- event_pulse  out  1  one-cycle pulse per accepted event
- last_edge  out  1  polarity of last accepted event (1 rising, 0 falling)
- event_count  out  COUNT_WIDTH  accepted events, saturating
- irq_pending  out  1  sticky event flag
- overrun  out  1  sticky: event accepted while irq_pending already set

## Operation
- level <= sync_in every cycle in all states. rise = sync_in & ~level; fall = ~sync_in & level.
- Candidate = (rise & edge_sel[0]) | (fall & edge_sel[1]). Accepted = candidate & state==ARMED.
- States: IDLE, ARMED, HOLDOFF.
  - IDLE: no events. enable=1 -> ARMED.
  - ARMED: accepted event and holdoff!=0 -> HOLDOFF, hold_cnt <= holdoff. holdoff==0 -> stay ARMED (back-to-back events each cycle allowed).
  - HOLDOFF: candidates ignored and lost (not deferred). hold_cnt decrements each cycle; leave to ARMED on the edge where hold_cnt==1, so exactly holdoff cycles are blocked.
  - enable=0 in any state -> IDLE next edge, hold_cnt <= 0. Counter, irq_pending, overrun, last_edge retained.
- On accepted event: event_pulse=1 for one cycle; last_edge <= rise; event_count += 1 saturating at all-ones; irq_pending <= 1.
- overrun <= 1 when event accepted while irq_pending=1 and irq_ack=0.
- holdoff sampled only at the accepting edge; later changes do not affect a running window.
- Simultaneous events:
  - count_clear + accepted event: event_count = 1.
  - irq_ack + accepted event: irq_pending stays 1, overrun cleared and not set.
  - edge_sel==00: level tracks, nothing accepted.

## Timing
- Reset (resn=0, asynchronous): state IDLE, level=0, event_pulse=0, last_edge=0, event_count=0, irq_pending=0, overrun=0, hold_cnt=0.
- Reset release is synchronous to clk via deassertion; state is IDLE for at least one cycle after reset so level loads sync_in before detection (no spurious edge if sync_in=1 at reset release).
- Latency: sync_in toggles after edge k -> event_pulse, count, irq_pending, last_edge updated at edge k+1 (one cycle).
- enable rising at edge k -> ARMED at edge k+1; transitions visible at edge k+2 onward are eligible.
- count_clear / irq_ack take effect at the next edge; outputs registered, no combinational paths input to output.
- Reset mid-HOLDOFF: window aborted, all state as reset.

## Test plan
- Reset with sync_in=1, release, enable=1, edge_sel=01, hold sync_in=1 20 cycles -> no event_pulse, event_count=0.
- edge_sel=11, holdoff=0, toggle sync_in every cycle for 6 cycles -> 6 pulses, event_count=6, last_edge matches final transition, overrun=1 after second event.
- holdoff=4, rising at cycle 0, further edges at cycles 2 and 4 with edge_sel=11 -> cycle-2 edge ignored, cycle-4 edge... (window covers cycles 1-4) ignored; edge at cycle 6 accepted; event_count=2.
- event_count preset to 0xFFFE via events (COUNT_WIDTH=16 or reduced width 2 for speed: 3 events) -> saturates at all-ones; count_clear same cycle as event -> count=1.
- irq_pending=1, irq_ack coincident with new event -> irq_pending=1, overrun=0; irq_ack alone next cycle -> both 0.
- enable dropped mid-HOLDOFF, re-enabled after 2 cycles -> edge 2 cycles after re-enable accepted; count and irq retained across disable; async resn pulse mid-HOLDOFF clears all outputs immediately.
